// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioner: repeat FSM states,
// counter width helper and board timing constants.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    REPEATING  = 2'd2
  } rpt_state_e;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * CYCLES_PER_MS;
  endfunction

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release
// strobes and the auto-repeat FSM.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_o,
  output logic rpt
);

  localparam int unsigned CNT_W  = cnt_w(STABLE_CYCLES);
  localparam int unsigned RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RC_W   = cnt_w(RC_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0]  PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, s_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rpt_q;
  logic [RC_W-1:0]  rc_q;
  rpt_state_e       state_q;

  // Any cycle where s agrees with level restarts the stability count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s_q;
        press_d = s_q;
        rel_d   = ~s_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      s_q     <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Repeat FSM keys off the same-cycle press/release events so rpt timing
  // is measured from the press strobe itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rc_q    <= '0;
      rpt_q   <= 1'b0;
    end else begin
      rpt_q <= 1'b0;
      rc_q  <= rc_q + RC_W'(1);
      if (rel_d || !repeat_en) begin
        state_q <= IDLE;
        rc_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            rc_q <= '0;
            if (press_d) state_q <= WAIT_FIRST;
          end
          WAIT_FIRST: begin
            if (rc_q == DELAY_LAST) begin
              rpt_q   <= 1'b1;
              rc_q    <= '0;
              state_q <= REPEATING;
            end
          end
          REPEATING: begin
            if (rc_q == PERIOD_LAST) begin
              rpt_q <= 1'b1;
              rc_q  <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            rc_q    <= '0;
          end
        endcase
      end
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_o = rel_q;
  assign rpt       = rpt_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel pushbutton conditioner: N independent debounce/repeat
// channels between the raw button pins and the game logic.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned STABLE_CYCLES = ms_to_cycles(20),
  parameter int unsigned REPEAT_DELAY  = ms_to_cycles(500),
  parameter int unsigned REPEAT_PERIOD = ms_to_cycles(100)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_raw,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_o,
  output logic [N-1:0] rpt
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw[i]),
      .repeat_en(repeat_en[i]),
      .level    (level[i]),
      .press    (press[i]),
      .release_o(release_o[i]),
      .rpt      (rpt[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with short timing constants
// (STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, N=4).
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] repeat_en;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] release_o;
  logic [3:0] rpt;

  int checks   = 0;
  int failures = 0;

  btn_debounce #(
    .N(4), .STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .repeat_en(repeat_en),
    .level    (level),
    .press    (press),
    .release_o(release_o),
    .rpt      (rpt)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then looked at 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    btn_raw   = 4'b0000;
    repeat_en = 4'b0000;
    step();
    step();
    checks++; if (level !== 4'b0000) begin failures++; $display("FAIL reset.level got=%b exp=0000", level); end
    checks++; if (press !== 4'b0000) begin failures++; $display("FAIL reset.press got=%b exp=0000", press); end
    checks++; if (release_o !== 4'b0000) begin failures++; $display("FAIL reset.release got=%b exp=0000", release_o); end
    checks++; if (rpt !== 4'b0000) begin failures++; $display("FAIL reset.rpt got=%b exp=0000", rpt); end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) step();
    checks++; if (level !== 4'b0000) begin failures++; $display("FAIL reset.idle_level got=%b exp=0000", level); end
  endtask

  task automatic test_clean_press();
    logic [3:0] el, ep, er;
    btn_raw = 4'b0001;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 40) btn_raw[0] = 1'b0;
      el = (c >= 6 && c < 46) ? 4'b0001 : 4'b0000;
      ep = (c == 6)  ? 4'b0001 : 4'b0000;
      er = (c == 46) ? 4'b0001 : 4'b0000;
      checks++; if (level !== el) begin failures++; $display("FAIL clean.level c=%0d got=%b exp=%b", c, level, el); end
      checks++; if (press !== ep) begin failures++; $display("FAIL clean.press c=%0d got=%b exp=%b", c, press, ep); end
      checks++; if (release_o !== er) begin failures++; $display("FAIL clean.release c=%0d got=%b exp=%b", c, release_o, er); end
      checks++; if (rpt !== 4'b0000) begin failures++; $display("FAIL clean.rpt c=%0d got=%b exp=0000", c, rpt); end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] ep, er;
    btn_raw = 4'b0010;
    for (int c = 1; c <= 55; c++) begin
      step();
      case (c)
        3:  btn_raw[1] = 1'b0;
        6:  btn_raw[1] = 1'b1;
        9:  btn_raw[1] = 1'b0;
        12: btn_raw[1] = 1'b1;
        40: btn_raw[1] = 1'b0;
        default: ;
      endcase
      ep = (c == 18) ? 4'b0010 : 4'b0000;
      er = (c == 46) ? 4'b0010 : 4'b0000;
      checks++; if (press !== ep) begin failures++; $display("FAIL bounce.press c=%0d got=%b exp=%b", c, press, ep); end
      checks++; if (release_o !== er) begin failures++; $display("FAIL bounce.release c=%0d got=%b exp=%b", c, release_o, er); end
    end
  endtask

  task automatic test_auto_repeat();
    logic [3:0] erpt, ep, er;
    repeat_en = 4'b0100;
    btn_raw   = 4'b0100;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (c == 45) btn_raw[2] = 1'b0;
      erpt = (c == 16 || c == 21 || c == 26 || c == 31 || c == 36 || c == 41 || c == 46)
             ? 4'b0100 : 4'b0000;
      ep = (c == 6)  ? 4'b0100 : 4'b0000;
      er = (c == 51) ? 4'b0100 : 4'b0000;
      checks++; if (rpt !== erpt) begin failures++; $display("FAIL repeat.rpt c=%0d got=%b exp=%b", c, rpt, erpt); end
      checks++; if (press !== ep) begin failures++; $display("FAIL repeat.press c=%0d got=%b exp=%b", c, press, ep); end
      checks++; if (release_o !== er) begin failures++; $display("FAIL repeat.release c=%0d got=%b exp=%b", c, release_o, er); end
    end
  endtask

  task automatic test_repeat_cancel();
    logic [3:0] erpt, er;
    repeat_en = 4'b0100;
    btn_raw   = 4'b0100;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (c == 17) repeat_en[2] = 1'b0;
      if (c == 26) repeat_en[2] = 1'b1;
      if (c == 45) btn_raw[2]   = 1'b0;
      erpt = (c == 16) ? 4'b0100 : 4'b0000;
      er   = (c == 51) ? 4'b0100 : 4'b0000;
      checks++; if (rpt !== erpt) begin failures++; $display("FAIL cancel.rpt c=%0d got=%b exp=%b", c, rpt, erpt); end
      checks++; if (release_o !== er) begin failures++; $display("FAIL cancel.release c=%0d got=%b exp=%b", c, release_o, er); end
    end
    repeat_en = 4'b0000;
  endtask

  task automatic test_reset_mid_debounce();
    logic [3:0] el, ep, er;
    btn_raw = 4'b1000;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (c == 5) begin
        checks++; if (level !== 4'b0000) begin failures++; $display("FAIL rstmid.level got=%b exp=0000", level); end
        checks++; if (press !== 4'b0000) begin failures++; $display("FAIL rstmid.press got=%b exp=0000", press); end
        checks++; if (release_o !== 4'b0000) begin failures++; $display("FAIL rstmid.release got=%b exp=0000", release_o); end
        checks++; if (rpt !== 4'b0000) begin failures++; $display("FAIL rstmid.rpt got=%b exp=0000", rpt); end
      end
      if (c == 4)  rst_n = 1'b0;
      if (c == 5)  rst_n = 1'b1;
      if (c == 20) btn_raw[3] = 1'b0;
      el = (c >= 11 && c < 26) ? 4'b1000 : 4'b0000;
      ep = (c == 11) ? 4'b1000 : 4'b0000;
      er = (c == 26) ? 4'b1000 : 4'b0000;
      checks++; if (level !== el) begin failures++; $display("FAIL rstmid.level_trace c=%0d got=%b exp=%b", c, level, el); end
      checks++; if (press !== ep) begin failures++; $display("FAIL rstmid.press_trace c=%0d got=%b exp=%b", c, press, ep); end
      checks++; if (release_o !== er) begin failures++; $display("FAIL rstmid.release_trace c=%0d got=%b exp=%b", c, release_o, er); end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] el, ep, er;
    btn_raw = 4'b1111;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 20) btn_raw = 4'b1110;
      if (c == 25) btn_raw = 4'b0000;
      el = (c < 6) ? 4'b0000 : (c < 26) ? 4'b1111 : (c < 31) ? 4'b1110 : 4'b0000;
      ep = (c == 6) ? 4'b1111 : 4'b0000;
      er = (c == 26) ? 4'b0001 : (c == 31) ? 4'b1110 : 4'b0000;
      checks++; if (level !== el) begin failures++; $display("FAIL simul.level c=%0d got=%b exp=%b", c, level, el); end
      checks++; if (press !== ep) begin failures++; $display("FAIL simul.press c=%0d got=%b exp=%b", c, press, ep); end
      checks++; if (release_o !== er) begin failures++; $display("FAIL simul.release c=%0d got=%b exp=%b", c, release_o, er); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_repeat_cancel();
    test_reset_mid_debounce();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
